// File: rtl/mac_tx_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mac_tx_multi                                                  |
// | Purpose  : Ethernet MAC transmit framer with a multi-slot header RAM.    |
// |            Each packet picks a header slot on its first beat. The frame  |
// |            is preamble, SFD, header bytes, payload, zero pad up to the   |
// |            minimum length and (optionally) the CRC-32 FCS. A fixed       |
// |            inter-frame gap follows every frame.                          |
// | Macro    : MAC_TX_FCS_EN - when defined, a 4-byte CRC-32 FCS is appended |
// |            and Mac_last marks its final byte. When undefined, the frame  |
// |            ends (Mac_last) on the last payload/pad byte.                 |
// | Ports    : Clk, Rst            - clock, synchronous active-high reset    |
// |            Header_wr_*         - header RAM write port (word wide)       |
// |            Payload_valid/ready/data/last/hdr_sel - byte payload input    |
// |            Mac_valid/ready/data/last            - registered byte output |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mac_tx_multi #(
    parameter  int NUM_HEADERS     = 4,
    parameter  int HEADER_BYTES    = 14,
    parameter  int MIN_FRAME_BYTES = 60,
    parameter  int IFG_CYCLES      = 12,
    localparam int WPS             = (HEADER_BYTES + 3) / 4,
    localparam int HDR_AW          = (NUM_HEADERS * WPS > 1) ? $clog2(NUM_HEADERS * WPS) : 1,
    localparam int c_SEL_W         = (NUM_HEADERS > 1) ? $clog2(NUM_HEADERS) : 1
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Header_wr_en,
    input  logic [HDR_AW-1:0]  Header_wr_addr,
    input  logic [31:0]        Header_wr_data,
    input  logic               Payload_valid,
    output logic               Payload_ready,
    input  logic [7:0]         Payload_data,
    input  logic               Payload_last,
    input  logic [c_SEL_W-1:0] Payload_hdr_sel,
    output logic               Mac_valid,
    output logic [7:0]         Mac_data,
    output logic               Mac_last,
    input  logic               Mac_ready
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_PRE     = 3'd1;
    localparam logic [2:0] c_ST_SFD     = 3'd2;
    localparam logic [2:0] c_ST_HEADER  = 3'd3;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd4;
    localparam logic [2:0] c_ST_PAD     = 3'd5;
`ifdef MAC_TX_FCS_EN
    localparam logic [2:0] c_ST_FCS     = 3'd6;
`endif
    localparam logic [2:0] c_ST_IFG     = 3'd7;

    localparam int          c_DEPTH    = 1 << HDR_AW;
    localparam logic [15:0] c_HDR_LAST = 16'(HEADER_BYTES - 1);
    localparam logic [15:0] c_MIN      = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] c_IFG      = 16'(IFG_CYCLES);

    // Header RAM: no reset, writable at any time (including during Rst).
    logic [31:0] r_hdr_ram [0:c_DEPTH-1];

    always_ff @(posedge Clk) begin
        if (Header_wr_en) begin
            r_hdr_ram[Header_wr_addr] <= Header_wr_data;
        end
    end

    logic [2:0]         r_state, w_state_nxt;
    logic [15:0]        r_idx, w_idx_nxt;        // preamble / header / FCS / IFG index
    logic [15:0]        r_frame_cnt, w_frame_nxt; // header+payload+pad bytes issued
    logic [c_SEL_W-1:0] r_sel, w_sel_nxt;
    logic               r_mac_valid, w_valid_nxt;
    logic [7:0]         r_mac_data, w_data_nxt;
    logic               r_mac_last, w_last_nxt;

    logic               w_load_ok;
    logic               w_body_load;
    logic [15:0]        w_frame_inc;
    logic [15:0]        w_idx_inc;
    logic [HDR_AW-1:0]  w_hdr_addr;
    logic [31:0]        w_hdr_word;
    logic [7:0]         w_hdr_byte;

    // The output register may take a new byte when empty or being drained.
    assign w_load_ok   = !r_mac_valid || Mac_ready;
    assign w_frame_inc = r_frame_cnt + 16'd1;
    assign w_idx_inc   = r_idx + 16'd1;

    assign w_hdr_addr  = HDR_AW'(r_sel) * HDR_AW'(WPS) + HDR_AW'(r_idx[15:2]);
    assign w_hdr_word  = r_hdr_ram[w_hdr_addr];
    assign w_hdr_byte  = w_hdr_word[{r_idx[1:0], 3'b000} +: 8];

`ifdef MAC_TX_FCS_EN
    logic [31:0] r_crc, w_crc_nxt;
    logic [7:0]  w_fcs_byte;

    // Reflected CRC-32, one byte, LSB first.
    function automatic logic [31:0] f_crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 8; b++) begin
            if (c[0] ^ data[b]) begin
                c = (c >> 1) ^ 32'hEDB8_8320;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign w_fcs_byte = ~r_crc[{r_idx[1:0], 3'b000} +: 8];
`endif

    assign Payload_ready = !Rst && (r_state == c_ST_PAYLOAD) && w_load_ok;
    assign Mac_valid     = r_mac_valid;
    assign Mac_data      = r_mac_data;
    assign Mac_last      = r_mac_last;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_frame_nxt = r_frame_cnt;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_mac_valid;
        w_data_nxt  = r_mac_data;
        w_last_nxt  = r_mac_last;
        w_body_load = 1'b0;
`ifdef MAC_TX_FCS_EN
        w_crc_nxt   = r_crc;
`endif
        case (r_state)
            c_ST_IDLE: begin
                // Start on a waiting packet; its first beat is not consumed here.
                if (Payload_valid) begin
                    w_state_nxt = c_ST_PRE;
                    w_sel_nxt   = Payload_hdr_sel;
                    w_idx_nxt   = 16'd0;
                end
            end
            c_ST_PRE: begin
                if (w_load_ok) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = 8'h55;
                    w_last_nxt  = 1'b0;
                    if (r_idx == 16'd6) begin
                        w_state_nxt = c_ST_SFD;
                        w_idx_nxt   = 16'd0;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                    end
                end
            end
            c_ST_SFD: begin
                if (w_load_ok) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = 8'hD5;
                    w_state_nxt = c_ST_HEADER;
                    w_idx_nxt   = 16'd0;
                    w_frame_nxt = 16'd0;
`ifdef MAC_TX_FCS_EN
                    w_crc_nxt   = 32'hFFFF_FFFF;
`endif
                end
            end
            c_ST_HEADER: begin
                if (w_load_ok) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_hdr_byte;
                    w_body_load = 1'b1;
                    if (r_idx == c_HDR_LAST) begin
                        w_state_nxt = c_ST_PAYLOAD;
                        w_idx_nxt   = 16'd0;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                    end
                end
            end
            c_ST_PAYLOAD: begin
                if (w_load_ok) begin
                    if (Payload_valid) begin
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = Payload_data;
                        w_body_load = 1'b1;
                        if (Payload_last) begin
                            if (w_frame_inc < c_MIN) begin
                                w_state_nxt = c_ST_PAD;
                            end else begin
`ifdef MAC_TX_FCS_EN
                                w_state_nxt = c_ST_FCS;
`else
                                w_last_nxt  = 1'b1;
                                w_state_nxt = c_ST_IFG;
`endif
                                w_idx_nxt   = 16'd0;
                            end
                        end
                    end else begin
                        // Source starved: drain the output and wait, frame stays open.
                        w_valid_nxt = 1'b0;
                    end
                end
            end
            c_ST_PAD: begin
                if (w_load_ok) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = 8'h00;
                    w_body_load = 1'b1;
                    if (w_frame_inc >= c_MIN) begin
`ifdef MAC_TX_FCS_EN
                        w_state_nxt = c_ST_FCS;
`else
                        w_last_nxt  = 1'b1;
                        w_state_nxt = c_ST_IFG;
`endif
                        w_idx_nxt   = 16'd0;
                    end
                end
            end
`ifdef MAC_TX_FCS_EN
            c_ST_FCS: begin
                if (w_load_ok) begin
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = w_fcs_byte;
                    if (r_idx == 16'd3) begin
                        w_last_nxt  = 1'b1;
                        w_state_nxt = c_ST_IFG;
                        w_idx_nxt   = 16'd0;
                    end else begin
                        w_idx_nxt   = w_idx_inc;
                    end
                end
            end
`endif
            c_ST_IFG: begin
                // First let the final beat drain, then count idle cycles.
                if (w_load_ok) begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                    if (!r_mac_valid) begin
                        if (w_idx_inc >= c_IFG) begin
                            w_state_nxt = c_ST_IDLE;
                            w_idx_nxt   = 16'd0;
                        end else begin
                            w_idx_nxt   = w_idx_inc;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase

        if (w_body_load) begin
            w_frame_nxt = w_frame_inc;
`ifdef MAC_TX_FCS_EN
            w_crc_nxt   = f_crc_byte(r_crc, w_data_nxt);
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= c_ST_IDLE;
            r_idx       <= 16'd0;
            r_frame_cnt <= 16'd0;
            r_sel       <= '0;
            r_mac_valid <= 1'b0;
            r_mac_data  <= 8'h00;
            r_mac_last  <= 1'b0;
`ifdef MAC_TX_FCS_EN
            r_crc       <= 32'hFFFF_FFFF;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_sel       <= w_sel_nxt;
            r_mac_valid <= w_valid_nxt;
            r_mac_data  <= w_data_nxt;
            r_mac_last  <= w_last_nxt;
`ifdef MAC_TX_FCS_EN
            r_crc       <= w_crc_nxt;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mac_tx_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mac_tx_multi                                               |
// | Purpose  : Self-checking bench for mac_tx_multi. Expected frames are     |
// |            built from a shadow of the header RAM and a software CRC-32   |
// |            and queued when a packet is driven; a monitor pops and        |
// |            compares every accepted output beat.                          |
// | Macro    : MAC_TX_FCS_EN - must match the build of the design.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mac_tx_multi;

    localparam int NUM_HEADERS     = 4;
    localparam int HEADER_BYTES    = 14;
    localparam int MIN_FRAME_BYTES = 60;
    localparam int IFG_CYCLES      = 12;
    localparam int WPS             = (HEADER_BYTES + 3) / 4;
    localparam int HDR_AW          = $clog2(NUM_HEADERS * WPS);
    localparam int SEL_W           = $clog2(NUM_HEADERS);
`ifdef MAC_TX_FCS_EN
    localparam int FCS_BYTES       = 4;
`else
    localparam int FCS_BYTES       = 0;
`endif

    logic              Clk;
    logic              Rst;
    logic              Header_wr_en;
    logic [HDR_AW-1:0] Header_wr_addr;
    logic [31:0]       Header_wr_data;
    logic              Payload_valid;
    logic              Payload_ready;
    logic [7:0]        Payload_data;
    logic              Payload_last;
    logic [SEL_W-1:0]  Payload_hdr_sel;
    logic              Mac_valid;
    logic [7:0]        Mac_data;
    logic              Mac_last;
    logic              Mac_ready;

    mac_tx_multi #(
        .NUM_HEADERS     (NUM_HEADERS),
        .HEADER_BYTES    (HEADER_BYTES),
        .MIN_FRAME_BYTES (MIN_FRAME_BYTES),
        .IFG_CYCLES      (IFG_CYCLES)
    ) u_dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Header_wr_en    (Header_wr_en),
        .Header_wr_addr  (Header_wr_addr),
        .Header_wr_data  (Header_wr_data),
        .Payload_valid   (Payload_valid),
        .Payload_ready   (Payload_ready),
        .Payload_data    (Payload_data),
        .Payload_last    (Payload_last),
        .Payload_hdr_sel (Payload_hdr_sel),
        .Mac_valid       (Mac_valid),
        .Mac_data        (Mac_data),
        .Mac_last        (Mac_last),
        .Mac_ready       (Mac_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] hdr_shadow [0:NUM_HEADERS*WPS-1];
    logic [8:0]  exp_q [$];          // {last, data}
    logic [7:0]  pl [0:1599];

    int n_vec = 0;
    int n_fail = 0;
    int beat_cnt = 0;
    int frames_done = 0;
    int last_frame_beats = 0;
    int idle_run = 0;
    int last_gap = -1;
    int drv_timeouts = 0;
    bit rand_ready = 1'b0;

    // Back-pressure source.
    initial begin
        Mac_ready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            Mac_ready = rand_ready ? ($urandom_range(0, 99) < 80) : 1'b1;
        end
    end

    // Output monitor: scoreboard pop/compare plus hold-while-stalled check.
    initial begin : mon
        bit         prev_stall;
        bit         prev_valid;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst !== 1'b0) begin
                prev_stall = 1'b0;
                prev_valid = 1'b0;
            end else begin
                if (prev_stall) begin
                    n_vec++;
                    if (Mac_valid !== 1'b1 || Mac_data !== prev_data || Mac_last !== prev_last) begin
                        n_fail++;
                        $display("FAIL stall_hold: got v=%b d=%h l=%b, held beat d=%h l=%b",
                                 Mac_valid, Mac_data, Mac_last, prev_data, prev_last);
                    end
                end
                if (Mac_valid === 1'b1 && !prev_valid && beat_cnt == 0 && frames_done > 0) begin
                    last_gap = idle_run;
                end
                if (Mac_valid === 1'b1) idle_run = 0;
                else idle_run++;
                if (Mac_valid === 1'b1 && Mac_ready === 1'b1) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_unexpected: got d=%h l=%b, no beat expected", Mac_data, Mac_last);
                    end else begin
                        e = exp_q.pop_front();
                        if ({Mac_last, Mac_data} !== e) begin
                            n_fail++;
                            $display("FAIL beat[%0d]: got d=%h l=%b, expected d=%h l=%b",
                                     beat_cnt, Mac_data, Mac_last, e[7:0], e[8]);
                        end
                    end
                    beat_cnt++;
                    if (Mac_last === 1'b1) begin
                        frames_done++;
                        last_frame_beats = beat_cnt;
                        beat_cnt = 0;
                    end
                end
                prev_stall = (Mac_valid === 1'b1) && (Mac_ready !== 1'b1);
                prev_valid = (Mac_valid === 1'b1);
                prev_data  = Mac_data;
                prev_last  = Mac_last;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic write_hdr(input int addr, input logic [31:0] d);
        Header_wr_en   = 1'b1;
        Header_wr_addr = HDR_AW'(addr);
        Header_wr_data = d;
        @(posedge Clk);
        #1;
        Header_wr_en   = 1'b0;
        hdr_shadow[addr] = d;
    endtask

    task automatic fill_payload(input int len);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
    endtask

    // Model: builds the full expected frame for slot/payload and queues it.
    task automatic push_expected(input int slot, input int len);
        logic [7:0]  body [$];
        logic [31:0] crc;
        logic [31:0] w;
        bit          tail_last;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < HEADER_BYTES; i++) begin
            w = hdr_shadow[slot*WPS + i/4];
            body.push_back(w[8*(i%4) +: 8]);
        end
        for (int i = 0; i < len; i++) body.push_back(pl[i]);
        while (body.size() < MIN_FRAME_BYTES) body.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (body[i]) crc = crc_step(crc, body[i]);
        crc = ~crc;
`ifdef MAC_TX_FCS_EN
        tail_last = 1'b0;
`else
        tail_last = 1'b1;
`endif
        foreach (body[i]) exp_q.push_back({tail_last && (i == body.size() - 1), body[i]});
`ifdef MAC_TX_FCS_EN
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, crc[8*k +: 8]});
`endif
    endtask

    // Drives one payload byte and waits (bounded) for its handshake.
    task automatic drive_byte(input int slot, input logic [7:0] d, input bit last, output bit ok);
        int t;
        Payload_valid   = 1'b1;
        Payload_data    = d;
        Payload_last    = last;
        Payload_hdr_sel = SEL_W'(slot);
        t = 0;
        @(negedge Clk);
        while (Payload_ready !== 1'b1 && t < 5000) begin
            @(negedge Clk);
            t++;
        end
        ok = (Payload_ready === 1'b1);
        @(posedge Clk);
        #1;
    endtask

    task automatic send_packet(input int slot, input int len, input bit gaps);
        bit ok;
        push_expected(slot, len);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                Payload_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge Clk);
                #1;
            end
            drive_byte(slot, pl[i], i == len - 1, ok);
            if (!ok) begin
                drv_timeouts++;
                break;
            end
        end
        Payload_valid = 1'b0;
        Payload_last  = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 20000) begin
            @(posedge Clk);
            t++;
        end
        #1;
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        Payload_valid = 1'b1;
        Payload_last = 1'b0;
        Payload_data = 8'h00;
        Payload_hdr_sel = '0;
        Header_wr_en = 1'b0;
        Header_wr_addr = '0;
        Header_wr_data = '0;
        repeat (2) @(posedge Clk);
        #1;
        // Header RAM is written while reset is held.
        for (int a = 0; a < NUM_HEADERS*WPS; a++) write_hdr(a, $urandom);
        @(negedge Clk);
        n_vec++;
        if (Mac_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", Mac_valid); end
        n_vec++;
        if (Mac_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b, expected 0", Mac_last); end
        n_vec++;
        if (Payload_ready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b, expected 0", Payload_ready); end
        @(posedge Clk);
        #1;
        Payload_valid = 1'b0;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_vec++;
        if (Mac_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b, expected 0", Mac_valid); end
    endtask

    task automatic test_short_frame;
        int base;
        write_hdr(2*WPS + 0, 32'h0403_0201);
        write_hdr(2*WPS + 1, 32'h0807_0605);
        write_hdr(2*WPS + 2, 32'h0C0B_0A09);
        write_hdr(2*WPS + 3, 32'hA5A5_0E0D);
        base = frames_done;
        fill_payload(1);
        send_packet(2, 1, 1'b0);
        wait_frames(base + 1);
        n_vec++;
        if (frames_done !== base + 1) begin n_fail++; $display("FAIL short_frames: got %0d, expected %0d", frames_done, base + 1); end
        n_vec++;
        if (last_frame_beats !== 8 + MIN_FRAME_BYTES + FCS_BYTES) begin
            n_fail++; $display("FAIL short_beats: got %0d, expected %0d", last_frame_beats, 8 + MIN_FRAME_BYTES + FCS_BYTES);
        end
        n_vec++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL short_leftover: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_no_pad;
        int base;
        int lens [2];
        lens[0] = 46;
        lens[1] = 1500;
        for (int k = 0; k < 2; k++) begin
            base = frames_done;
            fill_payload(lens[k]);
            send_packet(k, lens[k], 1'b0);
            wait_frames(base + 1);
            n_vec++;
            if (last_frame_beats !== 8 + HEADER_BYTES + lens[k] + FCS_BYTES || frames_done !== base + 1) begin
                n_fail++;
                $display("FAIL nopad_beats len=%0d: got %0d beats, expected %0d", lens[k], last_frame_beats,
                         8 + HEADER_BYTES + lens[k] + FCS_BYTES);
            end
        end
        n_vec++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL nopad_leftover: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int base;
        base = frames_done;
        last_gap = -1;
        fill_payload(5);
        send_packet(0, 5, 1'b0);
        fill_payload(50);
        send_packet(1, 50, 1'b0);
        wait_frames(base + 2);
        n_vec++;
        if (frames_done !== base + 2) begin n_fail++; $display("FAIL b2b_frames: got %0d, expected %0d", frames_done, base + 2); end
        n_vec++;
        if (last_gap < IFG_CYCLES) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles, expected >= %0d", last_gap, IFG_CYCLES); end
        n_vec++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_random;
        int base;
        int slot;
        base = frames_done;
        rand_ready = 1'b1;
        for (int p = 0; p < 200; p++) begin
            slot = $urandom_range(0, NUM_HEADERS - 1);
            fill_payload($urandom_range(1, 60));
            send_packet(slot, $urandom_range(1, 60), 1'b1);
            if (p % 50 == 49) begin
                wait_frames(base + p + 1);
                for (int w = 0; w < WPS; w++) write_hdr((p % NUM_HEADERS)*WPS + w, $urandom);
            end
        end
        wait_frames(base + 200);
        rand_ready = 1'b0;
        n_vec++;
        if (frames_done !== base + 200) begin n_fail++; $display("FAIL random_frames: got %0d, expected %0d", frames_done, base + 200); end
        n_vec++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL random_leftover: got %0d, expected 0", exp_q.size()); end
        n_vec++;
        if (drv_timeouts !== 0) begin n_fail++; $display("FAIL payload_timeouts: got %0d, expected 0", drv_timeouts); end
    endtask

    task automatic test_reset_midframe;
        int  base;
        bit  ok;
        repeat (20) @(posedge Clk);
        #1;
        base = frames_done;
        fill_payload(100);
        push_expected(3, 100);
        for (int i = 0; i < 100; i++) begin
            drive_byte(3, pl[i], i == 99, ok);
            if (!ok) drv_timeouts++;
            if (!ok || beat_cnt >= 30) break;
        end
        Payload_valid = 1'b0;
        Payload_last  = 1'b0;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        n_vec++;
        if (Mac_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", Mac_valid); end
        n_vec++;
        if (Mac_last !== 1'b0) begin n_fail++; $display("FAIL rstmid_last: got %b, expected 0", Mac_last); end
        // Upstream drops the rest of the abandoned packet.
        exp_q.delete();
        beat_cnt = 0;
        n_vec++;
        if (frames_done !== base) begin n_fail++; $display("FAIL rstmid_no_last: got %0d frames, expected %0d", frames_done, base); end
        fill_payload(10);
        send_packet(0, 10, 1'b0);
        wait_frames(base + 1);
        n_vec++;
        if (last_frame_beats !== 8 + MIN_FRAME_BYTES + FCS_BYTES || frames_done !== base + 1) begin
            n_fail++; $display("FAIL rstmid_next_beats: got %0d, expected %0d", last_frame_beats, 8 + MIN_FRAME_BYTES + FCS_BYTES);
        end
        n_vec++;
        if (exp_q.size() !== 0 || drv_timeouts !== 0) begin
            n_fail++; $display("FAIL rstmid_leftover: got %0d queued / %0d timeouts, expected 0/0", exp_q.size(), drv_timeouts);
        end
    endtask

    initial begin
        test_reset();
        test_short_frame();
        test_no_pad();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
